// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the inter-stage pipeline registers: the NOP opcode,
// the packed layout of the non-opcode fields, and the skid occupancy states.
package pipe_stage_skid_pkg;

    // Opcode presented downstream whenever a stage register holds no instruction
    localparam logic [5:0] OP_NOP = 6'b110111;

    // Non-opcode fields carried between stages, most significant field first
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  aux;
        logic [31:0] dm_addr;
        logic [31:0] imm_dpl;
        logic [31:0] addr;
        logic [31:0] os;
        logic [31:0] ot;
    } pipe_fields_t;

    // Width of the packed payload bus (207 bits for the layout above)
    localparam int PAYLOAD_BITS = $bits(pipe_fields_t);

    // Occupancy of the two entry registers: nothing, main only, main plus skid
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

    // Flattens the field struct onto the payload bus used by every stage register
    function automatic logic [PAYLOAD_BITS-1:0] pack_fields(input pipe_fields_t f);
        return f;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_cnt.sv
// Saturating up-counter with synchronous clear; also used for the hazard
// unit's stall statistics, so it carries no knowledge of the pipeline itself.
module pipe_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rstd,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = '1;

    // Clear wins over increment; the count sticks at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake and a one-deep
// skid entry behind the main entry, so a stalled consumer never causes a beat
// to be dropped or repeated. Flush turns the stage into a NOP bubble.
// All outputs come straight from registers: nothing combinational runs from
// the upstream side to the downstream side or back.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int              OP_W      = 6,
    parameter logic [OP_W-1:0] NOP_OP    = OP_NOP,
    parameter int              PAYLOAD_W = PAYLOAD_BITS,
    parameter int              CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rstd,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_W-1:0]      in_op,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OP_W-1:0]      out_op,
    output logic [PAYLOAD_W-1:0] out_payload,
    input  logic                 clr_cnt,
    output logic [CNT_W-1:0]     bubble_cnt
);

    skid_state_t state;
    skid_state_t state_nxt;

    logic                 accept;
    logic                 drain;
    logic                 load_main_in;
    logic                 load_main_skid;
    logic                 load_skid;
    logic                 kill_main_op;

    logic [OP_W-1:0]      main_op;
    logic [PAYLOAD_W-1:0] main_payload;
    logic [OP_W-1:0]      skid_op;
    logic [PAYLOAD_W-1:0] skid_payload;

    // Both handshake flags depend only on the occupancy register
    assign out_valid   = (state != ST_EMPTY);
    assign in_ready    = (state != ST_FULL);
    assign out_op      = main_op;
    assign out_payload = main_payload;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    // Occupancy register
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next occupancy and entry-load selects; flush overrides every handshake
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        kill_main_op   = 1'b0;
        if (flush) begin
            state_nxt    = ST_EMPTY;
            kill_main_op = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        load_main_in = 1'b1;
                        state_nxt    = ST_MAIN;
                    end
                end
                ST_MAIN: begin
                    if (accept && drain) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_nxt = ST_FULL;
                    end else if (drain) begin
                        kill_main_op = 1'b1;
                        state_nxt    = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so the skid entry is the only source
                    if (drain) begin
                        load_main_skid = 1'b1;
                        state_nxt      = ST_MAIN;
                    end
                end
                default: begin
                    kill_main_op = 1'b1;
                    state_nxt    = ST_EMPTY;
                end
            endcase
        end
    end

    // Main entry: two-way load mux from the input or the skid entry; an
    // emptied stage shows NOP while its payload keeps the last value
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            main_op      <= NOP_OP;
            main_payload <= '0;
        end else if (kill_main_op) begin
            main_op <= NOP_OP;
        end else if (load_main_in) begin
            main_op      <= in_op;
            main_payload <= in_payload;
        end else if (load_main_skid) begin
            main_op      <= skid_op;
            main_payload <= skid_payload;
        end
    end

    // Skid entry captures a beat accepted while main is stalled
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            skid_op      <= NOP_OP;
            skid_payload <= '0;
        end else if (load_skid) begin
            skid_op      <= in_op;
            skid_payload <= in_payload;
        end
    end

    // Bubble cycles: downstream ready but nothing to hand it
    pipe_sat_cnt #(
        .W (CNT_W)
    ) u_bubble_cnt (
        .clk  (clk),
        .rstd (rstd),
        .clr  (clr_cnt),
        .inc  (out_ready & ~out_valid),
        .cnt  (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomised checks for pipe_stage_skid, built with a 4-bit
// bubble counter so saturation is reachable quickly.
module tb_pipe_stage_skid;
    import pipe_stage_skid_pkg::*;

    localparam int         OP_W  = 6;
    localparam int         PW    = 207;
    localparam int         CNT_W = 4;
    localparam logic [5:0] NOP   = 6'b110111;

    logic             clk;
    logic             rstd;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_op;
    logic [PW-1:0]    in_payload;
    logic             out_valid;
    logic             out_ready;
    logic [OP_W-1:0]  out_op;
    logic [PW-1:0]    out_payload;
    logic             clr_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    int errors = 0;
    int checks = 0;

    pipe_stage_skid #(
        .OP_W      (OP_W),
        .NOP_OP    (NOP),
        .PAYLOAD_W (PW),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rstd        (rstd),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_payload  (in_payload),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_payload (out_payload),
        .clr_cnt     (clr_cnt),
        .bubble_cnt  (bubble_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Payload derived from the opcode so a wrong entry shows up in the fields too
    function automatic logic [PW-1:0] mkpay(input logic [5:0] op);
        pipe_fields_t f;
        f         = '0;
        f.pc      = 32'h0040_0000 + (32'(op) << 2);
        f.rt      = op[4:0];
        f.os      = 32'hdead_0000 | 32'(op);
        f.ot      = ~32'(op);
        f.dm_addr = 32'h1000_0000 + 32'(op);
        return pack_fields(f);
    endfunction

    task automatic check_output(input string tag, input logic [255:0] obs, input logic [255:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [5:0] op, input logic rdy,
                                  input logic fl, input logic clr);
        in_valid   = v;
        in_op      = op;
        in_payload = mkpay(op);
        out_ready  = rdy;
        flush      = fl;
        clr_cnt    = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        logic [5:0] q[$];
        logic       exp_rdy;
        logic       exp_v;
        logic [5:0] exp_op;
        logic       rv;
        logic       rr;
        logic       rf;
        logic [5:0] rop;
        logic       drn;
        logic       acc;

        rstd = 1'b1;
        apply_stimulus(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        #1 rstd = 1'b0;
        #2;
        $display("[TB] reset state");
        check_output("rst_out_valid", out_valid, 1'b0);
        check_output("rst_out_op", out_op, NOP);
        check_output("rst_in_ready", in_ready, 1'b1);
        check_output("rst_bubble", bubble_cnt, 4'd0);
        check_output("rst_payload", out_payload, '0);
        #9 rstd = 1'b1;
        step();

        $display("[TB] streaming");
        for (int i = 1; i <= 8; i++) begin
            apply_stimulus(1'b1, 6'(i), 1'b1, 1'b0, 1'b0);
            step();
            check_output("stream_valid", out_valid, 1'b1);
            check_output("stream_op", out_op, 6'(i));
            check_output("stream_ready", in_ready, 1'b1);
            check_output("stream_payload", out_payload, mkpay(6'(i)));
        end
        apply_stimulus(1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
        step();
        check_output("stream_end_valid", out_valid, 1'b0);
        check_output("stream_end_op", out_op, NOP);

        $display("[TB] skid");
        apply_stimulus(1'b1, 6'd9, 1'b0, 1'b0, 1'b0);
        step();
        check_output("skid_main_op", out_op, 6'd9);
        check_output("skid_main_ready", in_ready, 1'b1);
        apply_stimulus(1'b1, 6'd5, 1'b0, 1'b0, 1'b0);
        step();
        check_output("skid_full_ready", in_ready, 1'b0);
        check_output("skid_full_op", out_op, 6'd9);
        check_output("skid_full_valid", out_valid, 1'b1);
        apply_stimulus(1'b1, 6'd7, 1'b0, 1'b0, 1'b0);
        step();
        check_output("skid_hold_ready", in_ready, 1'b0);
        check_output("skid_hold_op", out_op, 6'd9);
        apply_stimulus(1'b1, 6'd7, 1'b1, 1'b0, 1'b0);
        step();
        check_output("skid_drain_op", out_op, 6'd5);
        check_output("skid_drain_payload", out_payload, mkpay(6'd5));
        check_output("skid_drain_ready", in_ready, 1'b1);
        apply_stimulus(1'b1, 6'd7, 1'b1, 1'b0, 1'b0);
        step();
        check_output("skid_next_op", out_op, 6'd7);
        apply_stimulus(1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
        step();
        check_output("skid_empty_valid", out_valid, 1'b0);
        check_output("skid_empty_op", out_op, NOP);

        $display("[TB] flush");
        apply_stimulus(1'b1, 6'd10, 1'b0, 1'b0, 1'b0);
        step();
        apply_stimulus(1'b1, 6'd11, 1'b0, 1'b0, 1'b0);
        step();
        check_output("flush_pre_ready", in_ready, 1'b0);
        apply_stimulus(1'b1, 6'd12, 1'b0, 1'b1, 1'b0);
        step();
        check_output("flush_full_valid", out_valid, 1'b0);
        check_output("flush_full_op", out_op, NOP);
        check_output("flush_full_ready", in_ready, 1'b1);
        check_output("flush_full_payload", out_payload, mkpay(6'd10));
        apply_stimulus(1'b1, 6'd13, 1'b0, 1'b0, 1'b0);
        step();
        check_output("flush_refill_op", out_op, 6'd13);
        apply_stimulus(1'b1, 6'd14, 1'b0, 1'b1, 1'b0);
        step();
        check_output("flush_acc_valid", out_valid, 1'b0);
        check_output("flush_acc_ready", in_ready, 1'b1);
        check_output("flush_acc_payload", out_payload, mkpay(6'd13));
        apply_stimulus(1'b1, 6'd15, 1'b1, 1'b1, 1'b0);
        step();
        check_output("flush_empty_valid", out_valid, 1'b0);
        apply_stimulus(1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
        step();
        check_output("flush_after_valid", out_valid, 1'b0);
        check_output("flush_after_op", out_op, NOP);

        $display("[TB] bubble counter");
        apply_stimulus(1'b0, 6'd0, 1'b1, 1'b0, 1'b1);
        step();
        check_output("cnt_clear", bubble_cnt, 4'd0);
        apply_stimulus(1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
        repeat (5) step();
        check_output("cnt_five", bubble_cnt, 4'd5);
        repeat (15) step();
        check_output("cnt_sat", bubble_cnt, 4'd15);
        repeat (3) step();
        check_output("cnt_sat_hold", bubble_cnt, 4'd15);
        apply_stimulus(1'b0, 6'd0, 1'b1, 1'b0, 1'b1);
        step();
        check_output("cnt_clr_prio", bubble_cnt, 4'd0);
        apply_stimulus(1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
        step();
        check_output("cnt_one", bubble_cnt, 4'd1);
        apply_stimulus(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        step();
        check_output("cnt_no_ready", bubble_cnt, 4'd1);

        $display("[TB] reset mid-traffic");
        apply_stimulus(1'b1, 6'd20, 1'b0, 1'b0, 1'b0);
        step();
        apply_stimulus(1'b1, 6'd21, 1'b0, 1'b0, 1'b0);
        step();
        check_output("mid_pre_ready", in_ready, 1'b0);
        check_output("mid_pre_op", out_op, 6'd20);
        #2 rstd = 1'b0;
        #1;
        check_output("mid_rst_valid", out_valid, 1'b0);
        check_output("mid_rst_op", out_op, NOP);
        check_output("mid_rst_ready", in_ready, 1'b1);
        check_output("mid_rst_bubble", bubble_cnt, 4'd0);
        check_output("mid_rst_payload", out_payload, '0);
        apply_stimulus(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rstd = 1'b1;
        step();

        $display("[TB] random traffic");
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            exp_rdy = (q.size() < 2);
            exp_v   = (q.size() != 0);
            exp_op  = exp_v ? q[0] : NOP;
            check_output("rand_handshake", {in_ready, out_valid, out_op}, {exp_rdy, exp_v, exp_op});
            if (exp_v) begin
                check_output("rand_payload", out_payload, mkpay(q[0]));
            end
            rv  = ($urandom_range(0, 3) != 0);
            rr  = ($urandom_range(0, 2) != 0);
            rf  = ($urandom_range(0, 31) == 0);
            rop = 6'($urandom);
            apply_stimulus(rv, rop, rr, rf, 1'b0);
            if (rf) begin
                q.delete();
            end else begin
                drn = exp_v && rr;
                acc = rv && exp_rdy;
                if (drn) void'(q.pop_front());
                if (acc) q.push_back(rop);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
